// File: rtl/spi_cpu_pkg.sv
// Shared definitions for the SPI nibble CPU: opcodes, SPI READ framing and
// the state encoding used by both the CPU core and the SPI read master.
package spi_cpu_pkg;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_LDB  = 4'h1;
  localparam logic [3:0] OP_LDO  = 4'h2;
  localparam logic [3:0] OP_LDSA = 4'h3;
  localparam logic [3:0] OP_LDSB = 4'h4;
  localparam logic [3:0] OP_LSH  = 4'h5;
  localparam logic [3:0] OP_RSH  = 4'h6;
  localparam logic [3:0] OP_CLR  = 4'h7;
  localparam logic [3:0] OP_SNZA = 4'h8;
  localparam logic [3:0] OP_SNZS = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [7:0] READ_CMD  = 8'h03;
  localparam int         ADDR_BITS = 16;
  localparam int         XFER_BITS = 8 + ADDR_BITS + 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_EXEC_HI,
    ST_EXEC_LO
  } state_e;

endpackage

// File: rtl/spi_read_master.sv
// SPI mode-0 master that performs one READ (0x03) transaction of a single
// byte at {8'h00, addr}; SCK runs at clk/2 and MISO is sampled on SCK rise.
module spi_read_master
  import spi_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [4:0] LAST_BIT = 5'(XFER_BITS - 1);

  state_e                 state_q;
  logic [XFER_BITS-1:0]   tx_q;
  logic [7:0]             rx_q;
  logic [4:0]             cnt_q;
  logic                   cs_n_q;
  logic                   sck_q;
  logic                   mosi_q;
  logic                   done_q;

  // Each SHIFT bit takes two clocks: SCK rises (sample MISO), then SCK falls
  // (present the next MOSI bit), so MOSI only ever changes while SCK is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cs_n_q  <= 1'b0;
            tx_q    <= {READ_CMD, {(ADDR_BITS-8){1'b0}}, addr, 8'h00};
            state_q <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          mosi_q  <= tx_q[XFER_BITS-1];
          tx_q    <= {tx_q[XFER_BITS-2:0], 1'b0};
          cnt_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!sck_q) begin
            sck_q <= 1'b1;
            rx_q  <= {rx_q[6:0], miso};
          end else begin
            sck_q <= 1'b0;
            if (cnt_q == LAST_BIT) begin
              mosi_q  <= 1'b0;
              state_q <= ST_CS_HOLD;
            end else begin
              cnt_q  <= cnt_q + 5'd1;
              mosi_q <= tx_q[XFER_BITS-1];
              tx_q   <= {tx_q[XFER_BITS-2:0], 1'b0};
            end
          end
        end
        ST_CS_HOLD: begin
          cs_n_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign data = rx_q;
  assign cs_n = cs_n_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/spi_cpu_top.sv
// Nibble-instruction CPU that fetches each program byte from SPI RAM and
// executes the high nibble, then the low nibble, before fetching PC+1.
module spi_cpu_top
  import spi_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e     state_q;
  logic [7:0] a_q, a_d, b_q, b_d, s_q, s_d, o_q, o_d;
  logic [7:0] pc_q, ir_q;
  logic       valid_q, valid_d, skip_q, skip_d;
  logic       start_q;
  logic [3:0] op;
  logic       busy, done, cs_n, sck, mosi;
  logic [7:0] rd_data;
  logic       unused_ok;

  spi_read_master u_master (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_q),
    .addr  (pc_q),
    .busy  (busy),
    .done  (done),
    .data  (rd_data),
    .cs_n  (cs_n),
    .sck   (sck),
    .mosi  (mosi),
    .miso  (uio_in[2])
  );

  // A pending skip consumes exactly one execute slot, whatever it holds.
  always_comb begin
    op      = (state_q == ST_EXEC_HI) ? ir_q[7:4] : ir_q[3:0];
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    o_d     = o_q;
    valid_d = valid_q;
    skip_d  = skip_q;
    if (state_q == ST_EXEC_HI || state_q == ST_EXEC_LO) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else begin
        case (op)
          OP_LDA:  a_d = {4'b0, ui_in[3:0]};
          OP_LDB:  b_d = {4'b0, ui_in[7:4]};
          OP_LDO:  begin o_d = a_q; valid_d = 1'b1; end
          OP_LDSA: s_d = a_q;
          OP_LDSB: s_d = b_q;
          OP_LSH:  a_d = {a_q[6:0], 1'b0};
          OP_RSH:  a_d = {1'b0, a_q[7:1]};
          OP_CLR:  begin a_d = '0; b_d = '0; s_d = '0; valid_d = 1'b0; end
          OP_SNZA: skip_d = (a_q != 8'h00);
          OP_SNZS: skip_d = (s_q != 8'h00);
          OP_ADD:  a_d = a_q + b_q;
          OP_SUB:  a_d = a_q - b_q;
          OP_AND:  a_d = a_q & b_q;
          OP_OR:   a_d = a_q | b_q;
          OP_XOR:  a_d = a_q ^ b_q;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      o_q     <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      skip_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      skip_q  <= skip_d;
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!busy) begin
            start_q <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (done) begin
            ir_q    <= rd_data;
            state_q <= ST_EXEC_HI;
          end
        end
        ST_EXEC_HI: state_q <= ST_EXEC_LO;
        ST_EXEC_LO: begin
          pc_q    <= pc_q + 8'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign uo_out    = {valid_q, o_q[6:0]};
  assign uio_out   = {o_q[7], 3'b000, sck, 1'b0, mosi, cs_n};
  assign uio_oe    = 8'b1000_1011;
  assign unused_ok = &{1'b0, ena, uio_in[7:3], uio_in[1:0]};

endmodule

// File: tb/tb_spi_cpu_top.sv
// Self-checking bench for spi_cpu_top: a behavioural SPI RAM answers READs
// and an instruction-level model of the CPU predicts outputs after each byte.
module tb_spi_cpu_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe, uio_in;
  logic       misoQ = 1'b0;
  logic [7:0] junk = 8'h00;

  int checks = 0;
  int errors = 0;

  assign uio_in = {junk[7:3], misoQ, junk[1:0]};

  always #5 clk = ~clk;

  spi_cpu_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Behavioural SPI RAM: 256 bytes, READ only, sampled away from clk rise.
  logic [7:0]  ram [256];
  int          bitCnt = 0;
  int          fetchCount = 0;
  logic [31:0] shiftIn = '0;
  logic        prevSck = 1'b0;
  logic [7:0]  lastCmd = '0, lastAddrHi = '0, lastAddrLo = '0;

  always @(negedge clk) begin
    if (uio_out[0] !== 1'b0) begin
      if (bitCnt == 32) fetchCount++;
      bitCnt = 0;
    end else begin
      if (prevSck === 1'b0 && uio_out[3] === 1'b1) begin
        shiftIn = {shiftIn[30:0], uio_out[1]};
        bitCnt++;
        if (bitCnt == 24) begin
          lastCmd    = shiftIn[23:16];
          lastAddrHi = shiftIn[15:8];
          lastAddrLo = shiftIn[7:0];
        end
      end else if (prevSck === 1'b1 && uio_out[3] === 1'b0 && bitCnt >= 24 && bitCnt < 32) begin
        misoQ = ram[lastAddrLo][31-bitCnt];
      end
    end
    prevSck = uio_out[3];
  end

  // Instruction-level reference model, plain integer arithmetic.
  int mA, mB, mS, mO, mPc, mValid, mSkip;

  task automatic modelReset();
    mA = 0; mB = 0; mS = 0; mO = 0; mPc = 0; mValid = 0; mSkip = 0;
  endtask

  task automatic modelNibble(input int op, input int ui);
    if (mSkip != 0) begin
      mSkip = 0;
      return;
    end
    case (op)
      0:  mA = ui % 16;
      1:  mB = ui / 16;
      2:  begin mO = mA; mValid = 1; end
      3:  mS = mA;
      4:  mS = mB;
      5:  mA = (mA * 2) % 256;
      6:  mA = mA / 2;
      7:  begin mA = 0; mB = 0; mS = 0; mValid = 0; end
      8:  mSkip = (mA != 0) ? 1 : 0;
      9:  mSkip = (mS != 0) ? 1 : 0;
      10: mA = (mA + mB) % 256;
      11: mA = (mA - mB + 256) % 256;
      12: mA = mA & mB;
      13: mA = mA | mB;
      14: mA = mA ^ mB;
      default: ;
    endcase
  endtask

  task automatic modelByte(input int ui);
    int b;
    b = int'(ram[mPc]);
    modelNibble(b / 16, ui);
    modelNibble(b % 16, ui);
    mPc = (mPc + 1) % 256;
  endtask

  function automatic logic [7:0] expUo();
    return 8'(mValid * 128 + mO % 128);
  endfunction

  function automatic logic expO7();
    return (mO / 128) != 0;
  endfunction

  task automatic doReset(input logic [7:0] ui);
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = ui;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic fillRam(input logic [7:0] value);
    for (int i = 0; i < 256; i++) ram[i] = value;
  endtask

  // Waits for one completed fetch, then for both execute slots to retire.
  task automatic stepByte(output bit got);
    int startCnt;
    startCnt = fetchCount;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (fetchCount != startCnt) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bit got;
    fillRam(8'hFF);
    rst_n = 1'b0;
    ui_in = 8'($urandom);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_uo_out got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h01) begin errors++; $display("[TB] FAIL reset_uio_out got %h want 01", uio_out); end
    checks++; if (uio_oe !== 8'h8B) begin errors++; $display("[TB] FAIL reset_uio_oe got %h want 8b", uio_oe); end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    stepByte(got);
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL reset_first_fetch timed out");
    end else begin
      checks++; if (lastCmd !== 8'h03) begin errors++; $display("[TB] FAIL reset_cmd got %h want 03", lastCmd); end
      checks++; if ({lastAddrHi, lastAddrLo} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr got %h want 0000", {lastAddrHi, lastAddrLo}); end
    end
  endtask

  task automatic test_fetch();
    bit got;
    fillRam(8'hFF);
    ram[0] = 8'h02;
    ram[1] = 8'h22;
    doReset(8'h05);
    for (int i = 0; i < 2; i++) begin
      stepByte(got);
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL fetch_timeout byte %0d", i); break; end
      modelByte(int'(ui_in));
      checks++; if (uo_out !== expUo()) begin errors++; $display("[TB] FAIL fetch_uo byte %0d got %h want %h", i, uo_out, expUo()); end
      checks++; if (uo_out !== 8'h85) begin errors++; $display("[TB] FAIL fetch_const byte %0d got %h want 85", i, uo_out); end
    end
  endtask

  logic [7:0] arithOp  [3] = '{8'hA2, 8'hB2, 8'hE2};
  logic [7:0] arithWant[3] = '{8'h88, 8'hFE, 8'h86};

  task automatic test_arith();
    bit got;
    for (int v = 0; v < 3; v++) begin
      fillRam(8'hFF);
      ram[0] = 8'h10;
      ram[1] = arithOp[v];
      doReset(8'h53);
      for (int i = 0; i < 2; i++) begin
        stepByte(got);
        checks++;
        if (!got) begin errors++; $display("[TB] FAIL arith_timeout op %h", arithOp[v]); break; end
        modelByte(int'(ui_in));
        checks++; if (uo_out !== expUo()) begin errors++; $display("[TB] FAIL arith_uo op %h got %h want %h", arithOp[v], uo_out, expUo()); end
        checks++; if (uio_out[7] !== expO7()) begin errors++; $display("[TB] FAIL arith_o7 op %h got %b want %b", arithOp[v], uio_out[7], expO7()); end
      end
      checks++; if (uo_out !== arithWant[v]) begin errors++; $display("[TB] FAIL arith_const op %h got %h want %h", arithOp[v], uo_out, arithWant[v]); end
    end
  endtask

  task automatic test_skip();
    bit got;
    logic [7:0] want [3] = '{8'h00, 8'h00, 8'h81};
    fillRam(8'hFF);
    ram[0] = 8'h10;
    ram[1] = 8'h82;
    ram[2] = 8'h2F;
    doReset(8'h01);
    for (int i = 0; i < 3; i++) begin
      stepByte(got);
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL skip_timeout byte %0d", i); break; end
      modelByte(int'(ui_in));
      checks++; if (uo_out !== expUo()) begin errors++; $display("[TB] FAIL skip_uo byte %0d got %h want %h", i, uo_out, expUo()); end
      checks++; if (uo_out !== want[i]) begin errors++; $display("[TB] FAIL skip_const byte %0d got %h want %h", i, uo_out, want[i]); end
    end
  endtask

  task automatic test_multiply();
    bit got;
    logic [7:0] prog [16] = '{8'h71, 8'h05, 8'hA5, 8'hA2, 8'h8F, 8'h6A, 8'h3F, 8'h9F,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    fillRam(8'hFF);
    for (int i = 0; i < 16; i++) ram[i] = prog[i];
    doReset(8'h32);
    for (int i = 0; i < 16; i++) begin
      stepByte(got);
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL mul_timeout byte %0d", i); break; end
      modelByte(int'(ui_in));
      checks++; if (uo_out !== expUo()) begin errors++; $display("[TB] FAIL mul_trace byte %0d got %h want %h", i, uo_out, expUo()); end
    end
    checks++; if (uo_out !== 8'h91) begin errors++; $display("[TB] FAIL mul_result got %h want 91", uo_out); end
  endtask

  task automatic test_random();
    bit got;
    int expAddr;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    junk = 8'($urandom);
    ena  = 1'($urandom);
    doReset(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      stepByte(got);
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL rand_timeout byte %0d", i); break; end
      expAddr = mPc;
      modelByte(int'(ui_in));
      checks++; if (lastAddrLo !== 8'(expAddr)) begin errors++; $display("[TB] FAIL rand_addr byte %0d got %h want %h", i, lastAddrLo, 8'(expAddr)); end
      checks++; if (uo_out !== expUo()) begin errors++; $display("[TB] FAIL rand_uo byte %0d got %h want %h", i, uo_out, expUo()); end
      checks++; if (uio_out[7] !== expO7()) begin errors++; $display("[TB] FAIL rand_o7 byte %0d got %b want %b", i, uio_out[7], expO7()); end
      ui_in = 8'($urandom);
      junk  = 8'($urandom);
    end
  endtask

  task automatic test_wrap();
    bit got;
    int expAddr;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    doReset(8'($urandom));
    for (int i = 0; i < 258; i++) begin
      stepByte(got);
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL wrap_timeout byte %0d", i); break; end
      expAddr = mPc;
      modelByte(int'(ui_in));
      checks++; if (lastAddrLo !== 8'(expAddr)) begin errors++; $display("[TB] FAIL wrap_addr byte %0d got %h want %h", i, lastAddrLo, 8'(expAddr)); end
      checks++; if (uo_out !== expUo()) begin errors++; $display("[TB] FAIL wrap_uo byte %0d got %h want %h", i, uo_out, expUo()); end
      if (i == 256) begin
        checks++; if (lastAddrLo !== 8'h00) begin errors++; $display("[TB] FAIL wrap_to_zero got %h want 00", lastAddrLo); end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit got;
    bit csLow;
    fillRam(8'hFF);
    ram[0] = 8'h02;
    doReset(8'h05);
    stepByte(got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL abort_prefetch timed out"); end
    checks++; if (uo_out !== 8'h85) begin errors++; $display("[TB] FAIL abort_preload got %h want 85", uo_out); end
    csLow = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (uio_out[0] === 1'b0) begin csLow = 1'b1; break; end
    end
    checks++;
    if (!csLow) begin
      errors++; $display("[TB] FAIL abort_cs_fall timed out");
    end else begin
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (uio_out[0] !== 1'b1) begin errors++; $display("[TB] FAIL abort_cs_n got %b want 1", uio_out[0]); end
      checks++; if (uio_out[3] !== 1'b0) begin errors++; $display("[TB] FAIL abort_sck got %b want 0", uio_out[3]); end
      checks++; if (uo_out !== 8'h00) begin errors++; $display("[TB] FAIL abort_uo got %h want 00", uo_out); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      stepByte(got);
      checks++;
      if (!got) begin
        errors++; $display("[TB] FAIL abort_refetch timed out");
      end else begin
        checks++; if ({lastCmd, lastAddrHi, lastAddrLo} !== 24'h030000) begin errors++; $display("[TB] FAIL abort_refetch_addr got %h want 030000", {lastCmd, lastAddrHi, lastAddrLo}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arith();
    test_skip();
    test_multiply();
    test_random();
    test_wrap();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
